// File: rtl/obi_arbiter_2to1_pkg.sv
// Shared types for the 2:1 OBI arbiter: requester identity and fixed OBI side-band widths.
package obi_arbiter_2to1_pkg;

   localparam int unsigned OBI_BE_W   = 4;
   localparam int unsigned OBI_ATOP_W = 6;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } obi_src_t;

   function automatic obi_src_t other_src(input obi_src_t s);
      return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
   endfunction

endpackage

// File: rtl/obi_arbiter_2to1_src_fifo.sv
// In-order record of which requester owns each granted-but-unanswered bus transaction.
module obi_arbiter_2to1_src_fifo
   import obi_arbiter_2to1_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  obi_src_t      i_src,
   input  logic          i_pop,
   output obi_src_t      o_head,
   output logic [CW-1:0] o_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   obi_src_t      r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Pointers wrap at DEPTH, so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push = i_push & (r_count != CW'(DEPTH));
   assign w_pop  = i_pop  & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(DEPTH); k++) r_mem[k] <= SRC_INSTR;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_src;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Shares one OBI master port between instruction fetch (I) and LSU (D); responses are
// routed back in order to whichever requester issued the transaction.
module obi_arbiter_2to1
   import obi_arbiter_2to1_pkg::*;
#(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          DATA_PRIO       = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // instruction-fetch port
   input  logic                  i_req_i,
   output logic                  i_gnt_o,
   input  logic [WIDTH-1:0]      i_addr_i,
   input  logic                  i_we_i,
   input  logic [OBI_BE_W-1:0]   i_be_i,
   input  logic [WIDTH-1:0]      i_wdata_i,
   output logic                  i_rvalid_o,
   output logic [WIDTH-1:0]      i_rdata_o,
   output logic                  i_err_o,
   input  logic                  i_rready_i,
   // LSU port
   input  logic                  d_req_i,
   output logic                  d_gnt_o,
   input  logic [WIDTH-1:0]      d_addr_i,
   input  logic                  d_we_i,
   input  logic [OBI_BE_W-1:0]   d_be_i,
   input  logic [WIDTH-1:0]      d_wdata_i,
   output logic                  d_rvalid_o,
   output logic [WIDTH-1:0]      d_rdata_o,
   output logic                  d_err_o,
   input  logic                  d_rready_i,
   // system bus port
   output logic                  m_req_o,
   input  logic                  m_gnt_i,
   output logic [WIDTH-1:0]      m_addr_o,
   output logic                  m_we_o,
   output logic [OBI_BE_W-1:0]   m_be_o,
   output logic [WIDTH-1:0]      m_wdata_o,
   output logic [OBI_ATOP_W-1:0] m_atop_o,
   input  logic                  m_rvalid_i,
   input  logic [WIDTH-1:0]      m_rdata_i,
   input  logic                  m_err_i,
   output logic                  m_rready_o
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   logic          r_lock;
   obi_src_t      r_locked_src;
   obi_src_t      r_rr_ptr;
   obi_src_t      w_sel;
   obi_src_t      w_owner;
   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_req;
   logic          w_accept;
   logic          w_rsp_valid;
   logic          w_rready;
   logic          w_pop;
   logic          w_stray_rvalid;
   logic          w_locked_req;

   assign w_fifo_full  = (w_fifo_count == CW'(MAX_OUTSTANDING));
   assign w_fifo_empty = (w_fifo_count == '0);
   assign w_req        = (i_req_i | d_req_i) & ~w_fifo_full;
   assign w_accept     = w_req & m_gnt_i;

   // Source selection: a pending (ungranted) request keeps its source until granted.
   always_comb begin
      w_sel = SRC_INSTR;
      if (r_lock)                   w_sel = r_locked_src;
      else if (i_req_i && d_req_i)  w_sel = DATA_PRIO ? SRC_DATA : r_rr_ptr;
      else if (d_req_i)             w_sel = SRC_DATA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock       <= 1'b0;
         r_locked_src <= SRC_INSTR;
         r_rr_ptr     <= SRC_INSTR;
      end else begin
         if (w_req && !m_gnt_i) begin
            r_lock       <= 1'b1;
            r_locked_src <= w_sel;
         end else if (w_accept) begin
            r_lock <= 1'b0;
         end
         if (w_accept) r_rr_ptr <= other_src(w_sel);
      end
   end

   obi_arbiter_2to1_src_fifo #(
      .DEPTH   (MAX_OUTSTANDING)
   ) u_src_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_accept),
      .i_src   (w_sel),
      .i_pop   (w_pop),
      .o_head  (w_owner),
      .o_count (w_fifo_count)
   );

   assign w_rsp_valid    = m_rvalid_i & ~w_fifo_empty;
   assign w_rready       = ((w_owner == SRC_DATA) ? d_rready_i : i_rready_i) & ~w_fifo_empty;
   assign w_pop          = m_rvalid_i & w_rready;
   assign w_stray_rvalid = m_rvalid_i & w_fifo_empty;
   assign w_locked_req   = (r_locked_src == SRC_DATA) ? d_req_i : i_req_i;

   // Every output is forced low while reset is held.
   assign m_req_o    = rst_n & w_req;
   assign m_addr_o   = {WIDTH{rst_n}} & ((w_sel == SRC_DATA) ? d_addr_i : i_addr_i);
   assign m_we_o     = rst_n & ((w_sel == SRC_DATA) ? d_we_i : i_we_i);
   assign m_be_o     = {OBI_BE_W{rst_n}} & ((w_sel == SRC_DATA) ? d_be_i : i_be_i);
   assign m_wdata_o  = {WIDTH{rst_n}} & ((w_sel == SRC_DATA) ? d_wdata_i : i_wdata_i);
   assign m_atop_o   = '0;
   assign m_rready_o = rst_n & w_rready;

   assign i_gnt_o    = rst_n & w_accept & (w_sel == SRC_INSTR);
   assign d_gnt_o    = rst_n & w_accept & (w_sel == SRC_DATA);
   assign i_rvalid_o = rst_n & w_rsp_valid & (w_owner == SRC_INSTR);
   assign d_rvalid_o = rst_n & w_rsp_valid & (w_owner == SRC_DATA);
   assign i_rdata_o  = {WIDTH{rst_n}} & m_rdata_i;
   assign d_rdata_o  = {WIDTH{rst_n}} & m_rdata_i;
   assign i_err_o    = rst_n & m_err_i;
   assign d_err_o    = rst_n & m_err_i;

   // Protocol checks: stray responses are tolerated but reported; dropping a locked request is not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
      end else begin
         assert (!w_stray_rvalid)
            else $warning("obi_arbiter_2to1: m_rvalid_i with no outstanding transaction ignored");
         assert (!(r_lock && !w_locked_req))
            else $error("obi_arbiter_2to1: requester dropped req while its address phase was pending");
      end
   end

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Directed bench for obi_arbiter_2to1: one fixed-priority and one round-robin instance
// share stimulus; expected values are hand-derived per step.
module tb_obi_arbiter_2to1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req, i_we, i_rready, d_req, d_we, d_rready;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
   logic [3:0]  i_be, d_be;
   logic        m_gnt, m_rvalid, m_err;

   // priority instance outputs
   logic        p_i_gnt, p_i_rvalid, p_i_err, p_d_gnt, p_d_rvalid, p_d_err;
   logic        p_m_req, p_m_we, p_m_rready;
   logic [31:0] p_i_rdata, p_d_rdata, p_m_addr, p_m_wdata;
   logic [3:0]  p_m_be;
   logic [5:0]  p_m_atop;
   // round-robin instance outputs
   logic        r_i_gnt, r_i_rvalid, r_i_err, r_d_gnt, r_d_rvalid, r_d_err;
   logic        r_m_req, r_m_we, r_m_rready;
   logic [31:0] r_i_rdata, r_d_rdata, r_m_addr, r_m_wdata;
   logic [3:0]  r_m_be;
   logic [5:0]  r_m_atop;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   obi_arbiter_2to1 #(.WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIO(1'b1)) dut_p (
      .clk(clk), .rst_n(rst_n),
      .i_req_i(i_req), .i_gnt_o(p_i_gnt), .i_addr_i(i_addr), .i_we_i(i_we), .i_be_i(i_be),
      .i_wdata_i(i_wdata), .i_rvalid_o(p_i_rvalid), .i_rdata_o(p_i_rdata), .i_err_o(p_i_err),
      .i_rready_i(i_rready),
      .d_req_i(d_req), .d_gnt_o(p_d_gnt), .d_addr_i(d_addr), .d_we_i(d_we), .d_be_i(d_be),
      .d_wdata_i(d_wdata), .d_rvalid_o(p_d_rvalid), .d_rdata_o(p_d_rdata), .d_err_o(p_d_err),
      .d_rready_i(d_rready),
      .m_req_o(p_m_req), .m_gnt_i(m_gnt), .m_addr_o(p_m_addr), .m_we_o(p_m_we), .m_be_o(p_m_be),
      .m_wdata_o(p_m_wdata), .m_atop_o(p_m_atop), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
      .m_err_i(m_err), .m_rready_o(p_m_rready)
   );

   obi_arbiter_2to1 #(.WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIO(1'b0)) dut_r (
      .clk(clk), .rst_n(rst_n),
      .i_req_i(i_req), .i_gnt_o(r_i_gnt), .i_addr_i(i_addr), .i_we_i(i_we), .i_be_i(i_be),
      .i_wdata_i(i_wdata), .i_rvalid_o(r_i_rvalid), .i_rdata_o(r_i_rdata), .i_err_o(r_i_err),
      .i_rready_i(i_rready),
      .d_req_i(d_req), .d_gnt_o(r_d_gnt), .d_addr_i(d_addr), .d_we_i(d_we), .d_be_i(d_be),
      .d_wdata_i(d_wdata), .d_rvalid_o(r_d_rvalid), .d_rdata_o(r_d_rdata), .d_err_o(r_d_err),
      .d_rready_i(d_rready),
      .m_req_o(r_m_req), .m_gnt_i(m_gnt), .m_addr_o(r_m_addr), .m_we_o(r_m_we), .m_be_o(r_m_be),
      .m_wdata_o(r_m_wdata), .m_atop_o(r_m_atop), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
      .m_err_i(m_err), .m_rready_o(r_m_rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_we = 1'b0; i_be = 4'hF; i_addr = '0; i_wdata = '0; i_rready = 1'b1;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'hF; d_addr = '0; d_wdata = '0; d_rready = 1'b1;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      // outputs held low during reset even with live inputs
      @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0ABC; m_gnt = 1'b1;
      m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
      #1;
      chk("rst_m_req",    32'(r_m_req),    32'h0);
      chk("rst_m_addr",   r_m_addr,        32'h0);
      chk("rst_i_gnt",    32'(r_i_gnt),    32'h0);
      chk("rst_i_rvalid", 32'(r_i_rvalid), 32'h0);
      chk("rst_i_rdata",  r_i_rdata,       32'h0);
      chk("rst_m_rready", 32'(p_m_rready), 32'h0);
      chk("rst_count",    32'(dut_r.w_fifo_count), 32'h0);

      // 1: I alone, then its response
      do_reset();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
      #1;
      chk("t1_m_req",  32'(p_m_req), 32'h1);
      chk("t1_m_addr", p_m_addr,     32'h100);
      chk("t1_i_gnt",  32'(p_i_gnt), 32'h1);
      chk("t1_d_gnt",  32'(p_d_gnt), 32'h0);
      chk("t1_atop",   32'(p_m_atop), 32'h0);
      @(negedge clk);
      i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t1_i_rvalid", 32'(p_i_rvalid), 32'h1);
      chk("t1_i_rdata",  p_i_rdata,       32'hDEAD_BEEF);
      chk("t1_d_rvalid", 32'(p_d_rvalid), 32'h0);
      chk("t1_m_rready", 32'(p_m_rready), 32'h1);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      chk("t1_count_after", 32'(dut_r.w_fifo_count), 32'h0);

      // 2: contention with data priority, in-order responses D then I
      do_reset();
      @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h200; d_addr = 32'h300; m_gnt = 1'b1;
      #1;
      chk("t2_addr_d", p_m_addr,     32'h300);
      chk("t2_d_gnt",  32'(p_d_gnt), 32'h1);
      chk("t2_i_gnt0", 32'(p_i_gnt), 32'h0);
      @(negedge clk);
      d_req = 1'b0;
      #1;
      chk("t2_addr_i", p_m_addr,     32'h200);
      chk("t2_i_gnt1", 32'(p_i_gnt), 32'h1);
      @(negedge clk);
      i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11;
      #1;
      chk("t2_rsp1_d", 32'(p_d_rvalid), 32'h1);
      chk("t2_rsp1_i", 32'(p_i_rvalid), 32'h0);
      chk("t2_rsp1_data", p_d_rdata,    32'h11);
      @(negedge clk);
      m_rdata = 32'h22;
      #1;
      chk("t2_rsp2_i", 32'(p_i_rvalid), 32'h1);
      chk("t2_rsp2_d", 32'(p_d_rvalid), 32'h0);
      @(negedge clk);
      m_rvalid = 1'b0;

      // 3: round-robin selection held stable while the bus stalls
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_req = 1'b1; d_req = 1'b1; i_addr = 32'h400; d_addr = 32'h500; m_gnt = 1'b0;
         #1;
         chk("t3_stall_addr", r_m_addr,     32'h400);
         chk("t3_stall_req",  32'(r_m_req), 32'h1);
         chk("t3_stall_gnt",  32'(r_i_gnt), 32'h0);
      end
      @(negedge clk);
      m_gnt = 1'b1;
      #1;
      chk("t3_i_gnt",  32'(r_i_gnt), 32'h1);
      chk("t3_d_gnt",  32'(r_d_gnt), 32'h0);
      chk("t3_addr",   r_m_addr,     32'h400);
      @(negedge clk);
      #1;
      chk("t3_rr_d_gnt", 32'(r_d_gnt), 32'h1);
      chk("t3_rr_addr",  r_m_addr,     32'h500);

      // 4: FIFO full blocks requests, no bypass on a same-cycle pop
      @(negedge clk);
      #1;
      chk("t4_full_req_r", 32'(r_m_req), 32'h0);
      chk("t4_full_req_p", 32'(p_m_req), 32'h0);
      chk("t4_full_gnt",   32'(r_i_gnt), 32'h0);
      chk("t4_count",      32'(dut_r.w_fifo_count), 32'h2);
      @(negedge clk);
      m_rvalid = 1'b1; m_rdata = 32'hA1;
      #1;
      chk("t4_nobypass",  32'(r_m_req),    32'h0);
      chk("t4_rsp_i",     32'(r_i_rvalid), 32'h1);

      // 5: push and pop together at count 1
      @(negedge clk);
      m_rdata = 32'hA2;
      #1;
      chk("t5_req_back", 32'(r_m_req),    32'h1);
      chk("t5_i_gnt",    32'(r_i_gnt),    32'h1);
      chk("t5_rsp_d",    32'(r_d_rvalid), 32'h1);
      chk("t5_count_pre", 32'(dut_r.w_fifo_count), 32'h1);
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rdata = 32'hA3;
      #1;
      chk("t5_count_same", 32'(dut_r.w_fifo_count), 32'h1);
      chk("t5_owner_i",    32'(r_i_rvalid), 32'h1);
      chk("t5_owner_not_d", 32'(r_d_rvalid), 32'h0);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      chk("t5_drained", 32'(dut_r.w_fifo_count), 32'h0);

      // 6: reset with two outstanding, then a stray response
      do_reset();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h600; m_gnt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_req = 1'b0; m_gnt = 1'b0;
      #1;
      chk("t6_two_out", 32'(dut_r.w_fifo_count), 32'h2);
      @(negedge clk);
      rst_n = 1'b0; i_req = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0_0BAD;
      #1;
      chk("t6_rst_count",  32'(dut_r.w_fifo_count), 32'h0);
      chk("t6_rst_req",    32'(r_m_req),    32'h0);
      chk("t6_rst_rvalid", 32'(r_i_rvalid), 32'h0);
      chk("t6_rst_rready", 32'(r_m_rready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; i_req = 1'b0; m_rvalid = 1'b0;
      @(negedge clk);
      m_rvalid = 1'b1;
      #1;
      chk("t6_stray_i",     32'(r_i_rvalid), 32'h0);
      chk("t6_stray_d",     32'(r_d_rvalid), 32'h0);
      chk("t6_stray_rrdy",  32'(r_m_rready), 32'h0);
      chk("t6_stray_flag",  32'(dut_r.w_stray_rvalid), 32'h1);
      @(negedge clk);
      m_rvalid = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
